// File: rtl/text_write_sched.sv
// text_write_sched: shares the text engine character write port between the CPU and keyboard requesters,
// plus a clear-screen sequencer compiled in when TEXT_SCHED_CLEAR_EN is defined.
// Latency: accept edge -> o_update the next cycle; one character per 3+GAP_CYCLES cycles with immediate ack.
// Backpressure: ready is raised only in IDLE and only to the granted requester; requesters hold data until accepted.
module text_write_sched #(
  parameter int unsigned GAP_CYCLES     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter logic [7:0]  ATTR_CLR       = 8'h07
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_res,
  input  logic       i_cpu_valid,
  input  logic [7:0] i_cpu_ascii,
  input  logic [7:0] i_cpu_attr,
  output logic       o_cpu_ready,
  input  logic       i_kbd_valid,
  input  logic [7:0] i_kbd_ascii,
  input  logic [7:0] i_kbd_attr,
  output logic       o_kbd_ready,
  input  logic       i_clr,
  output logic       o_clr_busy,
  output logic       o_update,
  output logic [7:0] o_ascii,
  output logic [7:0] o_attr,
  input  logic       i_display_done,
  output logic       o_busy,
  output logic       o_timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

  // Last count value of each timed state; the shared counter restarts at 0 on entry.
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ptr_q, ptr_d;        // 0: CPU wins a tie, 1: keyboard wins a tie
  logic [7:0] ascii_q, ascii_d;
  logic [7:0] attr_q, attr_d;
  logic       timeout_q, timeout_d;
  logic       update_q;
  logic       busy_q;
  logic       cpu_rdy, kbd_rdy;
  logic       clr_go;              // clear sequencer owns the next IDLE slot
  logic       wait_exit;
  logic       gap_exit;

  assign wait_exit = (state_q == WAIT_DONE) && (i_display_done || (cnt_q == TO_LAST));
  assign gap_exit  = (state_q == GAP) && (cnt_q == GAP_LAST);

`ifdef TEXT_SCHED_CLEAR_EN
  logic        clr_pend_q, clr_pend_d;
  logic        clr_act_q, clr_act_d;
  logic [11:0] clr_cnt_q, clr_cnt_d;
  logic        clr_busy_q;

  assign clr_go     = clr_pend_q | clr_act_q;
  assign o_clr_busy = clr_busy_q;

  // Clear bookkeeping: latch the request, load the screen size at the first IDLE, count characters out.
  always_comb begin
    clr_pend_d = clr_pend_q;
    clr_act_d  = clr_act_q;
    clr_cnt_d  = clr_cnt_q;
    if (i_clr && !clr_pend_q && !clr_act_q) begin
      clr_pend_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (clr_pend_q) begin
          clr_pend_d = 1'b0;
          clr_act_d  = 1'b1;
          clr_cnt_d  = i_res ? 12'd3700 : 12'd2400;
        end
      end
      WAIT_DONE: begin
        if (clr_act_q && wait_exit) begin
          clr_cnt_d = clr_cnt_q - 12'd1;
        end
      end
      GAP: begin
        if (clr_act_q && gap_exit && (clr_cnt_q == 12'd0)) begin
          clr_act_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Clear sequencer registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clr_pend_q <= 1'b0;
      clr_act_q  <= 1'b0;
      clr_cnt_q  <= '0;
      clr_busy_q <= 1'b0;
    end else begin
      clr_pend_q <= clr_pend_d;
      clr_act_q  <= clr_act_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_busy_q <= clr_pend_d | clr_act_d;
    end
  end
`else
  logic unused_clr;

  assign unused_clr = i_clr ^ i_res;
  assign clr_go     = 1'b0;
  assign o_clr_busy = 1'b0;
`endif

  // Next state: arbitration in IDLE, one-cycle strobe, ack/timeout wait, settle gap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    ascii_d   = ascii_q;
    attr_d    = attr_q;
    timeout_d = timeout_q;
    cpu_rdy   = 1'b0;
    kbd_rdy   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (clr_go) begin
          ascii_d = 8'h20;
          attr_d  = ATTR_CLR;
          state_d = ISSUE;
        end else if (i_cpu_valid && (!ptr_q || !i_kbd_valid)) begin
          cpu_rdy = 1'b1;
          ascii_d = i_cpu_ascii;
          attr_d  = i_cpu_attr;
          ptr_d   = 1'b1;
          state_d = ISSUE;
        end else if (i_kbd_valid) begin
          kbd_rdy = 1'b1;
          ascii_d = i_kbd_ascii;
          attr_d  = i_kbd_attr;
          ptr_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (wait_exit) begin
          timeout_d = timeout_q | ~i_display_done;
          cnt_d     = '0;
          state_d   = GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (gap_exit) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, arbitration pointer and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= 1'b0;
      ascii_q   <= '0;
      attr_q    <= '0;
      timeout_q <= 1'b0;
      update_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      ascii_q   <= ascii_d;
      attr_q    <= attr_d;
      timeout_q <= timeout_d;
      update_q  <= (state_d == ISSUE);
      busy_q    <= (state_d != IDLE);
    end
  end

  assign o_cpu_ready = cpu_rdy;
  assign o_kbd_ready = kbd_rdy;
  assign o_update    = update_q;
  assign o_ascii     = ascii_q;
  assign o_attr      = attr_q;
  assign o_busy      = busy_q;
  assign o_timeout   = timeout_q;

endmodule
